// File: rtl/svs_monitor_ctrl.sv
// Sequencer for one svs_monitor macro: program, arm, capture counts, stream them as beats.
// Optional running-minimum tracking is enabled by defining SVS_MON_CTRL_MINMAX_EN.
module svs_monitor_ctrl #(
    parameter int NB_MON       = 30,
    parameter int COUNT_W      = 16,
    parameter int TARGET_W     = 4,
    parameter int TIMEOUT_W    = 20,
    parameter int SETUP_CYCLES = 2,
    parameter int COOL_CYCLES  = 2
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic                        cont_i,
    input  logic                        stop_i,
    input  logic [TARGET_W-1:0]         target_i,
    input  logic [NB_MON-1:0]           use_ro_i,
    input  logic [TIMEOUT_W-1:0]        timeout_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_timeout_o,
    output logic                        err_cfg_o,
    output logic                        mon_enable_o,
    output logic [TARGET_W-1:0]         mon_target_o,
    output logic [NB_MON-1:0]           mon_use_ro_o,
    input  logic                        mon_valid_i,
    input  logic [NB_MON*COUNT_W-1:0]   mon_count_i,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [4:0]                  res_idx_o,
    output logic [COUNT_W-1:0]          res_count_o,
    output logic                        res_last_o,
    output logic [COUNT_W-1:0]          min_count_o,
    output logic [4:0]                  min_idx_o
);

    // state | meaning
    // IDLE  | waiting for start
    // SETUP | settings applied to the macro, enable low
    // RUN   | macro enabled, waiting for valid / timeout / stop
    // DRAIN | streaming snapshot beats, enable low
    // COOL  | enable low before the next round or idle
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_COOL} state_t;

    localparam int PH_MAX = (SETUP_CYCLES > COOL_CYCLES) ? SETUP_CYCLES : COOL_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_t                 state;
    logic [PH_W-1:0]        ph_tmr;
    logic [TIMEOUT_W-1:0]   to_tmr;
    logic [TIMEOUT_W-1:0]   timeout_lat;
    logic [TARGET_W-1:0]    target_lat;
    logic [NB_MON-1:0]      use_lat;
    logic [NB_MON-1:0]      rem_mask;
    logic [NB_MON-1:0]      rem_next;
    logic                   cont_lat;
    logic                   stop_pend;
    logic                   done_set;
    logic [4:0]             first_use;
    logic [4:0]             first_next;
    logic [COUNT_W-1:0]     count_in [NB_MON];
    logic [COUNT_W-1:0]     snap     [NB_MON];

    function automatic logic [4:0] first_set(input logic [NB_MON-1:0] m);
        logic [4:0] r;
        r = '0;
        for (int i = NB_MON - 1; i >= 0; i--)
            if (m[i]) r = 5'(i);
        return r;
    endfunction

    function automatic logic single_bit(input logic [NB_MON-1:0] m);
        return (m & (m - NB_MON'(1))) == '0;
    endfunction

    for (genvar g = 0; g < NB_MON; g++) begin : g_unpack
        assign count_in[g] = mon_count_i[g*COUNT_W +: COUNT_W];
    end

    assign busy_o       = (state != S_IDLE);
    assign mon_target_o = target_lat;
    assign mon_use_ro_o = use_lat;
    assign rem_next     = rem_mask & ~(NB_MON'(1) << res_idx_o);
    assign first_use    = first_set(use_lat);
    assign first_next   = first_set(rem_next);
    assign done_set     = (state == S_COOL) && (ph_tmr == PH_W'(1));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            ph_tmr        <= '0;
            to_tmr        <= '0;
            timeout_lat   <= '0;
            target_lat    <= '0;
            use_lat       <= '0;
            rem_mask      <= '0;
            cont_lat      <= 1'b0;
            stop_pend     <= 1'b0;
            done_o        <= 1'b0;
            err_timeout_o <= 1'b0;
            err_cfg_o     <= 1'b0;
            mon_enable_o  <= 1'b0;
            res_valid_o   <= 1'b0;
            res_idx_o     <= '0;
            res_count_o   <= '0;
            res_last_o    <= 1'b0;
            for (int i = 0; i < NB_MON; i++) snap[i] <= '0;
        end else begin
            done_o    <= done_set;
            err_cfg_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (use_ro_i != '0) begin
                            use_lat       <= use_ro_i;
                            target_lat    <= target_i;
                            timeout_lat   <= timeout_i;
                            cont_lat      <= cont_i;
                            err_timeout_o <= 1'b0;
                            ph_tmr        <= PH_W'(SETUP_CYCLES - 1);
                            state         <= S_SETUP;
                        end else begin
                            err_cfg_o <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (stop_i) stop_pend <= 1'b1;
                    if (ph_tmr == '0) begin
                        mon_enable_o <= 1'b1;
                        to_tmr       <= timeout_lat;
                        state        <= S_RUN;
                    end else begin
                        ph_tmr <= ph_tmr - PH_W'(1);
                    end
                end
                S_RUN: begin
                    if (stop_i || stop_pend) begin
                        stop_pend    <= 1'b1;
                        mon_enable_o <= 1'b0;
                        ph_tmr       <= PH_W'(COOL_CYCLES - 1);
                        state        <= S_COOL;
                    end else if (mon_valid_i) begin
                        for (int i = 0; i < NB_MON; i++) snap[i] <= count_in[i];
                        rem_mask     <= use_lat;
                        res_valid_o  <= 1'b1;
                        res_idx_o    <= first_use;
                        res_count_o  <= count_in[first_use];
                        res_last_o   <= single_bit(use_lat);
                        mon_enable_o <= 1'b0;
                        state        <= S_DRAIN;
                    end else if (timeout_lat != '0 && to_tmr == TIMEOUT_W'(1)) begin
                        err_timeout_o <= 1'b1;
                        mon_enable_o  <= 1'b0;
                        ph_tmr        <= PH_W'(COOL_CYCLES - 1);
                        state         <= S_COOL;
                    end else begin
                        to_tmr <= to_tmr - TIMEOUT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (stop_i) stop_pend <= 1'b1;
                    if (res_ready_i) begin
                        if (rem_next == '0) begin
                            res_valid_o <= 1'b0;
                            res_last_o  <= 1'b0;
                            ph_tmr      <= PH_W'(COOL_CYCLES - 1);
                            state       <= S_COOL;
                        end else begin
                            rem_mask    <= rem_next;
                            res_idx_o   <= first_next;
                            res_count_o <= snap[first_next];
                            res_last_o  <= single_bit(rem_next);
                        end
                    end
                end
                S_COOL: begin
                    if (stop_i) stop_pend <= 1'b1;
                    if (ph_tmr == '0) begin
                        if (cont_lat && !stop_pend && !stop_i) begin
                            ph_tmr <= PH_W'(SETUP_CYCLES - 1);
                            state  <= S_SETUP;
                        end else begin
                            stop_pend <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end else begin
                        ph_tmr <= ph_tmr - PH_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SVS_MON_CTRL_MINMAX_EN
    logic [COUNT_W-1:0] run_min;
    logic [4:0]         run_idx;
    logic               capture;
    logic               beat_fire;

    assign capture   = (state == S_RUN) && !(stop_i || stop_pend) && mon_valid_i;
    assign beat_fire = (state == S_DRAIN) && res_valid_o && res_ready_i;

    // strict less-than keeps the lowest index on ties
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            run_min     <= '0;
            run_idx     <= '0;
            min_count_o <= '0;
            min_idx_o   <= '0;
        end else begin
            if (capture) begin
                run_min <= '1;
                run_idx <= '0;
            end else if (beat_fire && res_count_o < run_min) begin
                run_min <= res_count_o;
                run_idx <= res_idx_o;
            end
            if (done_set) begin
                min_count_o <= run_min;
                min_idx_o   <= run_idx;
            end
        end
    end
`else
    assign min_count_o = '0;
    assign min_idx_o   = '0;
`endif

endmodule

// File: tb/tb_svs_monitor_ctrl.sv
// Randomized self-checking bench for svs_monitor_ctrl against a beat-list reference model.
module tb_svs_monitor_ctrl;
    localparam int NB_MON       = 30;
    localparam int COUNT_W      = 16;
    localparam int TARGET_W     = 4;
    localparam int TIMEOUT_W    = 20;
    localparam int SETUP_CYCLES = 2;
    localparam int COOL_CYCLES  = 2;

    logic                      clock = 1'b0;
    logic                      rst;
    logic                      start_i, cont_i, stop_i;
    logic [TARGET_W-1:0]       target_i;
    logic [NB_MON-1:0]         use_ro_i;
    logic [TIMEOUT_W-1:0]      timeout_i;
    logic                      busy_o, done_o, err_timeout_o, err_cfg_o;
    logic                      mon_enable_o;
    logic [TARGET_W-1:0]       mon_target_o;
    logic [NB_MON-1:0]         mon_use_ro_o;
    logic                      mon_valid_i;
    logic [NB_MON*COUNT_W-1:0] mon_count_i;
    logic                      res_valid_o, res_ready_i, res_last_o;
    logic [4:0]                res_idx_o;
    logic [COUNT_W-1:0]        res_count_o;
    logic [COUNT_W-1:0]        min_count_o;
    logic [4:0]                min_idx_o;

    always #5 clock = ~clock;

    svs_monitor_ctrl #(
        .NB_MON(NB_MON), .COUNT_W(COUNT_W), .TARGET_W(TARGET_W), .TIMEOUT_W(TIMEOUT_W),
        .SETUP_CYCLES(SETUP_CYCLES), .COOL_CYCLES(COOL_CYCLES)
    ) dut (
        .clock(clock), .rst(rst), .start_i(start_i), .cont_i(cont_i), .stop_i(stop_i),
        .target_i(target_i), .use_ro_i(use_ro_i), .timeout_i(timeout_i),
        .busy_o(busy_o), .done_o(done_o), .err_timeout_o(err_timeout_o), .err_cfg_o(err_cfg_o),
        .mon_enable_o(mon_enable_o), .mon_target_o(mon_target_o), .mon_use_ro_o(mon_use_ro_o),
        .mon_valid_i(mon_valid_i), .mon_count_i(mon_count_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_idx_o(res_idx_o),
        .res_count_o(res_count_o), .res_last_o(res_last_o),
        .min_count_o(min_count_o), .min_idx_o(min_idx_o)
    );

    int                 n_chk = 0;
    int                 n_err = 0;
    int                 done_cnt, valid_seen;
    logic [COUNT_W-1:0] cnt_tb [NB_MON];
    logic [21:0]        got_q[$];
    logic [21:0]        exp_q[$];
    logic               prev_hold;
    logic [4:0]         prev_idx;
    logic [COUNT_W-1:0] prev_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one clock; records accepted beats and checks that a stalled beat stays put
    task automatic tick();
        if (res_valid_o && res_ready_i) got_q.push_back({res_last_o, res_idx_o, res_count_o});
        prev_hold  = res_valid_o && !res_ready_i;
        prev_idx   = res_idx_o;
        prev_count = res_count_o;
        @(posedge clock);
        #1;
        if (done_o) done_cnt++;
        if (res_valid_o) valid_seen++;
        if (prev_hold)
            chk("beat_hold", 32'({res_valid_o, res_idx_o, res_count_o}),
                32'({1'b1, prev_idx, prev_count}));
    endtask

    task automatic drive_counts();
        for (int i = 0; i < NB_MON; i++) mon_count_i[i*COUNT_W +: COUNT_W] = cnt_tb[i];
    endtask

    task automatic rand_counts();
        for (int i = 0; i < NB_MON; i++) cnt_tb[i] = COUNT_W'($urandom);
        drive_counts();
    endtask

    // expected beats: one per selected monitor, ascending index, last on the highest
    task automatic build_exp(input logic [NB_MON-1:0] m);
        int hi;
        hi = -1;
        exp_q.delete();
        for (int i = 0; i < NB_MON; i++) if (m[i]) hi = i;
        for (int i = 0; i < NB_MON; i++)
            if (m[i]) exp_q.push_back({(i == hi), 5'(i), cnt_tb[i]});
    endtask

    task automatic check_beats(input int reps);
        int n;
        n = exp_q.size();
        chk("beat_count", 32'(got_q.size()), 32'(n * reps));
        for (int r = 0; r < reps; r++)
            for (int j = 0; j < n; j++)
                if (r * n + j < got_q.size()) chk("beat", 32'(got_q[r*n+j]), 32'(exp_q[j]));
    endtask

    task automatic check_min();
        logic [COUNT_W-1:0] m;
        logic [4:0]         mi;
        m  = '1;
        mi = '0;
        foreach (exp_q[j])
            if (exp_q[j][15:0] < m) begin
                m  = exp_q[j][15:0];
                mi = exp_q[j][20:16];
            end
`ifdef SVS_MON_CTRL_MINMAX_EN
        chk("min_count", 32'(min_count_o), 32'(m));
        chk("min_idx", 32'(min_idx_o), 32'(mi));
`else
        chk("min_count_tied", 32'(min_count_o), 32'(m & '0));
        chk("min_idx_tied", 32'(min_idx_o), 32'(mi & '0));
`endif
    endtask

    task automatic start_cmd(input logic [NB_MON-1:0] use_m, input logic [TARGET_W-1:0] tgt,
                             input logic [TIMEOUT_W-1:0] to, input logic cont);
        start_i   = 1'b1;
        use_ro_i  = use_m;
        target_i  = tgt;
        timeout_i = to;
        cont_i    = cont;
        tick();
        start_i   = 1'b0;
        cont_i    = 1'b0;
        use_ro_i  = NB_MON'($urandom);
        target_i  = TARGET_W'($urandom);
        timeout_i = TIMEOUT_W'($urandom);
    endtask

    task automatic wait_enable();
        int k;
        k = 1;
        while (!mon_enable_o && k < 100) begin
            tick();
            k++;
        end
        chk("enable_rise", 32'(k), 32'(SETUP_CYCLES + 1));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_o && k < 500) begin
            tick();
            k++;
        end
        chk("idle_reached", 32'(busy_o), 32'(0));
    endtask

    // rmode: 0 ready held high, 1 random ready, 2 ready low for 5 cycles after the first beat
    task automatic shot(input logic [NB_MON-1:0] use_m, input logic [TARGET_W-1:0] tgt,
                        input logic [TIMEOUT_W-1:0] to, input int vdelay, input int rmode);
        int dc;
        got_q.delete();
        done_cnt   = 0;
        valid_seen = 0;
        build_exp(use_m);
        start_cmd(use_m, tgt, to, 1'b0);
        chk("err_timeout_cleared", 32'(err_timeout_o), 32'(0));
        chk("busy_after_start", 32'(busy_o), 32'(1));
        wait_enable();
        chk("mon_target", 32'(mon_target_o), 32'(tgt));
        chk("mon_use_ro", 32'(mon_use_ro_o), 32'(use_m));
        repeat (vdelay) tick();
        mon_valid_i = 1'b1;
        tick();
        mon_valid_i = 1'b0;
        chk("enable_off_in_drain", 32'(mon_enable_o), 32'(0));
        dc = 0;
        while (busy_o && dc < 500) begin
            case (rmode)
                0:       res_ready_i = 1'b1;
                1:       res_ready_i = 1'($urandom_range(0, 1));
                default: res_ready_i = (dc == 0 || dc >= 6);
            endcase
            tick();
            dc++;
        end
        res_ready_i = 1'b0;
        chk("drain_finished", 32'(busy_o), 32'(0));
        chk("done_pulses", 32'(done_cnt), 32'(1));
        chk("no_timeout_err", 32'(err_timeout_o), 32'(0));
        check_beats(1);
        check_min();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NB_MON-1:0] m;
        int vd, g;
        rst = 1'b1;
        start_i = 1'b0; cont_i = 1'b0; stop_i = 1'b0;
        target_i = '0; use_ro_i = '0; timeout_i = '0;
        mon_valid_i = 1'b0; mon_count_i = '0; res_ready_i = 1'b0;
        done_cnt = 0; valid_seen = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_outs", 32'({done_o, err_timeout_o, err_cfg_o, mon_enable_o, res_valid_o, res_last_o}), 32'(0));
        chk("rst_mon_cfg", 32'({mon_target_o, mon_use_ro_o}), 32'(0));
        chk("rst_res", 32'({res_idx_o, res_count_o}), 32'(0));
        chk("rst_min", 32'({min_idx_o, min_count_o}), 32'(0));
        rst = 1'b0;
        tick();

        // single shot: bits 0 and 2
        rand_counts();
        cnt_tb[0] = 16'h0100;
        cnt_tb[2] = 16'h0080;
        drive_counts();
        shot(30'h5, 4'd3, '0, 10, 0);

        // backpressure mid-drain
        rand_counts();
        shot(30'h0000_1234, 4'd7, '0, 3, 2);

        // config error and idle behaviour
        start_cmd('0, 4'd1, '0, 1'b0);
        chk("err_cfg_pulse", 32'(err_cfg_o), 32'(1));
        chk("err_cfg_not_busy", 32'(busy_o), 32'(0));
        tick();
        chk("err_cfg_one_cycle", 32'(err_cfg_o), 32'(0));
        chk("err_cfg_still_idle", 32'(busy_o), 32'(0));

        // timeout with no valid
        got_q.delete();
        done_cnt = 0;
        valid_seen = 0;
        start_cmd(30'h3, 4'd2, 20'd50, 1'b0);
        wait_enable();
        g = 1;
        while (mon_enable_o && g < 200) begin
            tick();
            if (mon_enable_o) g++;
        end
        chk("timeout_run_len", 32'(g), 32'(50));
        chk("timeout_err_set", 32'(err_timeout_o), 32'(1));
        wait_idle();
        chk("timeout_no_beats", 32'(valid_seen), 32'(0));
        chk("timeout_done", 32'(done_cnt), 32'(1));
        chk("timeout_sticky", 32'(err_timeout_o), 32'(1));

        // valid on the same cycle the timeout expires: valid wins (also clears the sticky error)
        rand_counts();
        shot(30'h2000_0001, 4'd9, 20'd6, 5, 1);

        // continuous mode, ignored start while busy, stop in the third RUN
        rand_counts();
        m = 30'h0000_0491;
        build_exp(m);
        got_q.delete();
        done_cnt = 0;
        start_cmd(m, 4'd4, '0, 1'b1);
        res_ready_i = 1'b1;
        for (int r = 0; r < 3; r++) begin
            g = 0;
            while (!mon_enable_o && g < 100) begin
                tick();
                g++;
            end
            chk("cont_enable", 32'(mon_enable_o), 32'(1));
            if (r == 2) begin
                repeat (3) tick();
                stop_i = 1'b1;
                tick();
                stop_i = 1'b0;
                chk("stop_enable_off", 32'(mon_enable_o), 32'(0));
                break;
            end
            if (r == 1) begin
                start_i  = 1'b1;
                use_ro_i = '0;
                tick();
                start_i  = 1'b0;
                chk("busy_start_no_cfg_err", 32'(err_cfg_o), 32'(0));
                chk("busy_start_ignored", 32'(mon_use_ro_o), 32'(m));
            end
            repeat (4) tick();
            mon_valid_i = 1'b1;
            tick();
            mon_valid_i = 1'b0;
            g = 1;
            while (!mon_enable_o && g < 100) begin
                tick();
                if (!mon_enable_o) g++;
            end
            chk("cont_gap", 32'(g), 32'($countones(m) + COOL_CYCLES + SETUP_CYCLES));
        end
        wait_idle();
        res_ready_i = 1'b0;
        chk("cont_done_pulses", 32'(done_cnt), 32'(3));
        check_beats(2);

        // min tracking with a tie on indices 4 and 7
        rand_counts();
        cnt_tb[1] = 16'h0200;
        cnt_tb[4] = 16'h0080;
        cnt_tb[7] = 16'h0080;
        drive_counts();
        shot(30'h0000_0092, 4'd5, '0, 2, 0);

        // randomized rounds
        for (int t = 0; t < 8; t++) begin
            rand_counts();
            m = NB_MON'($urandom);
            if (m == '0) m = NB_MON'(1) << $urandom_range(0, NB_MON - 1);
            vd = $urandom_range(0, 15);
            shot(m, TARGET_W'($urandom), ($urandom_range(0, 1) == 1) ? '0 : TIMEOUT_W'(vd + 1 + $urandom_range(0, 4)),
                 vd, 1);
        end

        // async reset in the middle of RUN
        start_cmd(30'h1, 4'd1, '0, 1'b1);
        wait_enable();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_enable", 32'(mon_enable_o), 32'(0));
        chk("async_rst_busy", 32'(busy_o), 32'(0));
        @(posedge clock);
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(busy_o), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/svs_monitor_ctrl.md
Name: svs_monitor_ctrl

Overview:
- Sequencer for one svs_monitor instance: programs target/use_ro while the monitor is disabled, arms it, waits for valid, snapshots the selected ring-oscillator counts, and streams them out one per beat over a valid/ready interface.
- Sits between the SVS/AVS register block (or firmware-driven CSR) and the svs_monitor macro.
- Supports single-shot and continuous measurement, abort, and timeout.

Parameters:
- NB_MON, 30, number of monitors / count ports on the macro
- COUNT_W, 16, width of each count
- TARGET_W, 4, width of the target exponent field
- TIMEOUT_W, 20, width of the timeout counter
- SETUP_CYCLES, 2, cycles that settings are held with enable low before arming; minimum 2
- COOL_CYCLES, 2, cycles enable is held low after a run; minimum 2

Ports:
- clock, in, 1, block clock; same clock as the monitor's clock pin
- rst, in, 1, asynchronous active-high reset
- start_i, in, 1, single-cycle request to begin a measurement
- cont_i, in, 1, sampled with start_i; 1 = continuous mode
- stop_i, in, 1, single-cycle abort / end-continuous request
- target_i, in, TARGET_W, sampled with start_i
- use_ro_i, in, NB_MON, sampled with start_i
- timeout_i, in, TIMEOUT_W, sampled with start_i; 0 disables the timeout
- busy_o, out, 1, FSM not in IDLE
- done_o, out, 1, one-cycle pulse at the end of each measurement round
- err_timeout_o, out, 1, sticky flag; cleared on an accepted start
- err_cfg_o, out, 1, one-cycle pulse when a start is rejected
- mon_enable_o, out, 1, to monitor enable
- mon_target_o, out, TARGET_W, to monitor target
- mon_use_ro_o, out, NB_MON, to monitor use_ro
- mon_valid_i, in, 1, from monitor valid
- mon_count_i, in, NB_MON*COUNT_W, flattened monitor counts; monitor i at bits [i*COUNT_W +: COUNT_W]
- res_valid_o, out, 1, result beat valid
- res_ready_i, in, 1, result beat accepted
- res_idx_o, out, 5, monitor index of the beat
- res_count_o, out, COUNT_W, count of the beat
- res_last_o, out, 1, final beat of the round
- min_count_o, out, COUNT_W, minimum count of the last round (optional feature)
- min_idx_o, out, 5, index of that minimum (optional feature)

Behaviour:
- Reset: FSM to IDLE; all outputs 0; snapshot, counters and latched config cleared.
- States: IDLE, SETUP, RUN, DRAIN, COOL.
- IDLE:
  - start_i with use_ro_i != 0: latch config, clear err_timeout_o, go to SETUP.
  - start_i with use_ro_i == 0: err_cfg_o pulses for one cycle; stay in IDLE.
  - start_i in any other state: ignored.
- SETUP:
  - mon_enable_o = 0; mon_target_o and mon_use_ro_o driven from the latched config (held stable from SETUP entry until IDLE).
  - After SETUP_CYCLES cycles, go to RUN.
  - Start accepted at cycle 0 -> mon_enable_o = 1 at cycle 1+SETUP_CYCLES.
- RUN:
  - mon_enable_o = 1; the timeout counter increments each cycle from 0.
  - mon_valid_i = 1: register all NB_MON counts in that same cycle, go to DRAIN.
  - Timeout counter reaching timeout_i (when nonzero) with no valid: set err_timeout_o, go to COOL, no results emitted.
  - stop_i: go to COOL, no results, no error.
  - valid and timeout in the same cycle: valid wins.
- DRAIN:
  - mon_enable_o = 0.
  - Emit one beat per set bit of the latched use mask, in ascending index order.
  - res_valid_o is held with stable idx/count until res_ready_i; advance on valid&&ready.
  - res_last_o is asserted on the highest-index selected beat.
  - Back-to-back beats are allowed (1 beat/cycle with ready held high).
  - After the last handshake, go to COOL.
  - stop_i in DRAIN is recorded; the drain completes.
- COOL:
  - mon_enable_o = 0 for COOL_CYCLES cycles.
  - done_o pulses in the last cycle.
  - Then go to SETUP if continuous mode is latched and no stop is pending; otherwise go to IDLE.
  - A stop pending flag is cleared on entry to IDLE.
- Counts wider than the monitor-masked value are never synthesized; snapshot width = COUNT_W.
- Async rst mid-operation: immediate return to IDLE; mon_enable_o = 0.

Optional Feature:
- Macro: SVS_MON_CTRL_MINMAX_EN.
- Defined:
  - Track the running minimum count and its index over the emitted beats.
  - Initialise to all-ones/0 at DRAIN entry.
  - A strict less-than updates the minimum, so on ties the lowest index wins.
  - min_count_o and min_idx_o update at done_o and hold until the next done_o.
- Undefined: min_count_o and min_idx_o are tied to 0, and no tracking logic is present.

Test Plan:
- Single shot, use_ro_i=0x5 (bits 0 and 2), target 3, SETUP_CYCLES=2; mon_valid_i after 10 cycles with counts[0]=0x0100, counts[2]=0x0080 -> mon_enable_o rises at cycle 3; two beats (0,0x0100), (2,0x0080); res_last_o on the second beat; done_o pulses once; busy_o returns to 0.
- Backpressure: res_ready_i low for 5 cycles mid-drain -> beat held stable, no beat lost or duplicated.
- Timeout: timeout_i=50, mon_valid_i never rises -> err_timeout_o=1 after 50 RUN cycles; no res_valid_o; done_o pulses; err_timeout_o cleared by the next start.
- Continuous mode: 3 rounds, then stop_i during the 3rd RUN -> 2 full result rounds, 3 done_o pulses, FSM returns to IDLE; mon_enable_o low ≥ COOL_CYCLES between rounds.
- start_i with use_ro_i=0 -> err_cfg_o pulses for one cycle, busy_o stays 0. start_i while busy -> ignored.
- MINMAX_EN: counts {0x0200,0x0080,0x0080} on indices 1, 4, 7 -> min_count_o=0x0080, min_idx_o=4.
